// File: rtl/demux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// demux_sel_sequencer
//
// Upstream driver for a 4-to-16 demultiplexer. Channel requests
// ({chan, data}) are queued in a small FIFO. They are then played out one at a
// time on sel/demux_in:
//   - each channel is held for HOLD_CYCLES cycles;
//   - a GAP_CYCLES guard follows, with demux_in low, so that sel only ever
//     changes while demux_in is 0.
// A sweep mode walks channels 0..15 with data=1 for bring-up and self-test.
//
// Parameters:
//   DEPTH        request FIFO depth (power of 2, >= 2)
//   HOLD_CYCLES  cycles each channel is driven (>= 1)
//   GAP_CYCLES   data-low guard cycles after each channel (0 allowed)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    request present
//   req_ready    FIFO can accept a request (registered)
//   req_chan     requested demux channel
//   req_data     value to route to that channel
//   sweep_start  single-cycle pulse; starts a 0..15 sweep when idle and empty
//   sel          demux select
//   demux_in     demux data input
//   active       high while a channel is being driven
//   done         one-cycle pulse at the end of each channel's hold
//   sweep_done   one-cycle pulse when a sweep has finished its last gap
//   fifo_count   current FIFO occupancy
//
// FSM states:
//   state | meaning
//   IDLE  | waiting; pops a request or steps the sweep, demux_in low
//   DRIVE | sel/demux_in driven for HOLD_CYCLES cycles, active high
//   GAP   | guard interval, demux_in low, sel held
// -----------------------------------------------------------------------------
module demux_sel_sequencer #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3:0]              req_chan,
    input  logic                    req_data,
    input  logic                    sweep_start,
    output logic [3:0]              sel,
    output logic                    demux_in,
    output logic                    active,
    output logic                    done,
    output logic                    sweep_done,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      chan_mem [DEPTH];
    logic            data_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TW-1:0]   tmr;
    logic            sweep_mode;
    logic [3:0]      sweep_chan;

    logic            push;
    logic            pop;
    logic            sweep_go;
    logic            tmr_last;
    logic            chan_end;
    logic            sweep_finish;
    logic            sweep_mode_nxt;
    logic [CNTW-1:0] count_nxt;

    // Handshake and FSM-side decisions.
    // pop and sweep_go are mutually exclusive: a sweep may only start when
    // the FIFO is empty.
    always_comb begin
        push     = req_valid && req_ready;
        pop      = (state == IDLE) && !sweep_mode && (fifo_count != '0);
        sweep_go = (state == IDLE) && !sweep_mode && (fifo_count == '0) && sweep_start;
        tmr_last = (tmr == TW'(1));

        // A channel slot ends on the last cycle of its gap.
        // With no gap, it ends on the last cycle of its hold.
        if (GAP_CYCLES == 0) begin
            chan_end = (state == DRIVE) && tmr_last;
        end else begin
            chan_end = (state == GAP) && tmr_last;
        end

        sweep_finish = sweep_mode && chan_end && (sweep_chan == 4'hF);

        sweep_mode_nxt = sweep_mode;
        if (sweep_go) begin
            sweep_mode_nxt = 1'b1;
        end else if (sweep_finish) begin
            sweep_mode_nxt = 1'b0;
        end

        count_nxt = fifo_count + CNTW'(push) - CNTW'(pop);
    end

    // FIFO storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (push) begin
            chan_mem[wr_ptr] <= req_chan;
            data_mem[wr_ptr] <= req_data;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            req_ready  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= count_nxt;
            req_ready  <= (count_nxt < CNTW'(DEPTH)) && !sweep_mode_nxt;
        end
    end

    // Sequencer FSM. tmr is a down-counter loaded on entry to DRIVE/GAP;
    // the state ends when tmr reaches 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= 4'd0;
            demux_in   <= 1'b0;
            active     <= 1'b0;
            done       <= 1'b0;
            sweep_done <= 1'b0;
            tmr        <= '0;
            sweep_mode <= 1'b0;
            sweep_chan <= 4'd0;
        end else begin
            done       <= 1'b0;
            sweep_done <= 1'b0;
            sweep_mode <= sweep_mode_nxt;

            case (state)
                IDLE: begin
                    if (pop) begin
                        sel      <= chan_mem[rd_ptr];
                        demux_in <= data_mem[rd_ptr];
                        active   <= 1'b1;
                        tmr      <= TW'(HOLD_CYCLES);
                        state    <= DRIVE;
                    end else if (sweep_go) begin
                        sel        <= 4'd0;
                        sweep_chan <= 4'd0;
                        demux_in   <= 1'b1;
                        active     <= 1'b1;
                        tmr        <= TW'(HOLD_CYCLES);
                        state      <= DRIVE;
                    end else if (sweep_mode) begin
                        // Sweep mode leaves IDLE only after channels below 15,
                        // because sweep_mode clears as channel 15 ends.
                        // The increment therefore never wraps.
                        sel        <= sweep_chan + 4'd1;
                        sweep_chan <= sweep_chan + 4'd1;
                        demux_in   <= 1'b1;
                        active     <= 1'b1;
                        tmr        <= TW'(HOLD_CYCLES);
                        state      <= DRIVE;
                    end else begin
                        demux_in <= 1'b0;
                    end
                end

                DRIVE: begin
                    if (tmr_last) begin
                        done     <= 1'b1;
                        active   <= 1'b0;
                        demux_in <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            sweep_done <= sweep_finish;
                            state      <= IDLE;
                        end else begin
                            tmr   <= TW'(GAP_CYCLES);
                            state <= GAP;
                        end
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end

                GAP: begin
                    demux_in <= 1'b0;
                    if (tmr_last) begin
                        sweep_done <= sweep_finish;
                        state      <= IDLE;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    active   <= 1'b0;
                    demux_in <= 1'b0;
                end
            endcase
        end
    end

endmodule
